tremolo_lfo: RTL and testbench
==============================

# tremolo_lfo

Sample-rate tremolo with an internal LFO. Each valid input sample is attenuated by an arithmetic right shift, and the shift amount sweeps as a triangle between 0 and a programmable depth. The sweep speed is programmable in samples per step. The block sits in the effects chain between the input sample source and the mixer/output stage, and is the clocked, self-modulating successor to the combinational shift-table tremolo.

## Interface

Parameters:
- DATA_WIDTH, 32, sample width, signed two's complement.
- SHIFT_WIDTH, 3, width of the shift index; maximum shift is 2^SHIFT_WIDTH-1.
- RATE_WIDTH, 16, width of the rate divider.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  tremolo enable. When low, the block passes samples through and holds the LFO in its reset state.
- x_valid  in  1  input sample strobe, one sample per asserted cycle.
- x  in  DATA_WIDTH  signed input sample.
- rate  in  RATE_WIDTH  number of valid samples per LFO step; 0 is treated as 1.
- depth  in  SHIFT_WIDTH  maximum shift, i.e. the peak of the triangle.
- mode  in  1  0 = triangle, 1 = square. Present only with TREMOLO_SQUARE_EN.
- y  out  DATA_WIDTH  signed output sample, registered.
- y_valid  out  1  output strobe.
- lfo_index  out  SHIFT_WIDTH  current shift index, for debug and metering.

## Operation

- State:
  - rate counter cnt (RATE_WIDTH)
  - shift index idx (SHIFT_WIDTH), driven on lfo_index
  - direction dir: UP or DOWN
- Reset values: y=0, y_valid=0, idx=0, cnt=0, dir=UP.
- On a cycle with x_valid=1 and en=1:
  - y <= x >>> idx, using idx before any update on that cycle. The shift is sign-preserving, so -1 >>> k = -1.
  - If cnt >= max(rate,1)-1: cnt <= 0 and the LFO steps. Otherwise cnt <= cnt+1.
- LFO step, triangle mode:
  - UP: if idx >= depth, then dir <= DOWN and idx <= max(idx-1, 0). Otherwise idx <= idx+1.
  - DOWN: if idx == 0, then dir <= UP and idx <= min(1, depth). Otherwise idx <= idx-1.
  - depth=0: idx stays 0 and y = x.
  - If depth drops below idx: on the next step, idx <= depth and dir <= DOWN.
- On a cycle with x_valid=1 and en=0: y <= x, and idx, cnt and dir are forced to their reset values.
- On a cycle with x_valid=0: y, cnt, idx and dir hold. The LFO advances only on samples, never on idle cycles.
- rate and depth are sampled on each step. Changing them mid-sweep takes effect from the next step, with no glitch on y.

## Timing

- Latency: y and y_valid appear 1 cycle after x and x_valid.
- y_valid is a registered copy of x_valid. It is independent of en.
- Throughput: one sample per clock. x_valid may stay high indefinitely.
- No backpressure: the downstream stage must accept every y_valid.
- reset wins over every other input in the same cycle. Asserting reset mid-sweep returns every output to its reset value on the next edge, and any in-flight sample is dropped (y_valid=0).
- An en edge takes effect on the first sample of the cycle in which it is sampled.

## Configuration

- TREMOLO_SQUARE_EN defined:
  - The mode port exists.
  - With mode=1, each LFO step toggles idx between 0 and depth, giving a hard chop. dir is unused.
  - With mode=0, behaviour is the triangle described above.
  - Switching mode takes effect at the next step, starting from the current idx.
- TREMOLO_SQUARE_EN undefined:
  - The mode port and its logic are absent.
  - The block is triangle-only.

## Test plan

- Reset: assert reset for 2 cycles with x_valid=1 and x=100 -> y=0, y_valid=0, lfo_index=0 throughout; the first post-reset output follows 1 cycle after the first sample.
- Bypass: en=0, x_valid=1, x ramps -5..5 -> y equals x delayed by 1 cycle, and lfo_index stays 0.
- Triangle: en=1, rate=2, depth=3, constant x=1024 -> y repeats the sequence 1024,1024,512,512,256,256,128,128,256,256,512,512,1024,1024,512...
- Sign and gaps: x=-256, depth=3, rate=1, x_valid toggling 1/0 -> y on valid samples is -256,-128,-64,-32,-64; y holds on idle cycles and lfo_index advances only on valid samples.
- Depth change and reset mid-sweep: at idx=5 with depth=7, set depth=2 -> next step gives idx=2 and dir DOWN; then assert reset -> idx=0, cnt=0, y=0 on the next edge.
- Square (TREMOLO_SQUARE_EN, mode=1, rate=1, depth=4, x=64) -> y alternates 64,4,64,4.

Source files
------------

// File: rtl/tremolo_lfo.sv
// Sample-rate tremolo: arithmetic right shift of each valid sample, with the shift swept by a triangle LFO.
// Optional square-wave chop mode is compiled in with `define TREMOLO_SQUARE_EN.
module tremolo_lfo #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHIFT_WIDTH = 3,
  parameter int RATE_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          x_valid,
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic        [RATE_WIDTH-1:0]  rate,
  input  logic        [SHIFT_WIDTH-1:0] depth,
`ifdef TREMOLO_SQUARE_EN
  input  logic                          mode,
`endif
  output logic signed [DATA_WIDTH-1:0]  y,
  output logic                          y_valid,
  output logic        [SHIFT_WIDTH-1:0] lfo_index
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [RATE_WIDTH-1:0]  RATE_ZERO = {RATE_WIDTH{1'b0}};
  localparam logic [RATE_WIDTH-1:0]  RATE_ONE  = RATE_WIDTH'(1);
  localparam logic [SHIFT_WIDTH-1:0] IDX_ZERO  = {SHIFT_WIDTH{1'b0}};
  localparam logic [SHIFT_WIDTH-1:0] IDX_ONE   = SHIFT_WIDTH'(1);

  logic signed [DATA_WIDTH-1:0]  y_r, y_nxt_s;
  logic                          y_valid_r;
  logic        [RATE_WIDTH-1:0]  cnt_r, cnt_nxt_s, rate_m1_s;
  logic        [SHIFT_WIDTH-1:0] idx_r, idx_nxt_s, idx_tri_s, idx_step_s;
  dir_t                          dir_r, dir_nxt_s, dir_tri_s, dir_step_s;
  logic                          step_s;

  assign rate_m1_s = (rate == RATE_ZERO) ? RATE_ZERO : (rate - RATE_ONE);
  assign step_s    = (cnt_r >= rate_m1_s);

  // Triangle step; a depth lowered below idx clamps to depth and heads down.
  always_comb begin
    idx_tri_s = idx_r;
    dir_tri_s = dir_r;
    if (idx_r > depth) begin
      idx_tri_s = depth;
      dir_tri_s = DIR_DOWN;
    end else if (dir_r == DIR_UP) begin
      if (idx_r >= depth) begin
        dir_tri_s = DIR_DOWN;
        idx_tri_s = (idx_r == IDX_ZERO) ? IDX_ZERO : (idx_r - IDX_ONE);
      end else begin
        idx_tri_s = idx_r + IDX_ONE;
      end
    end else begin
      if (idx_r == IDX_ZERO) begin
        dir_tri_s = DIR_UP;
        idx_tri_s = (depth == IDX_ZERO) ? IDX_ZERO : IDX_ONE;
      end else begin
        idx_tri_s = idx_r - IDX_ONE;
      end
    end
  end

  // Select the LFO waveform applied on a step.
  always_comb begin
    idx_step_s = idx_tri_s;
    dir_step_s = dir_tri_s;
`ifdef TREMOLO_SQUARE_EN
    if (mode) begin
      idx_step_s = (idx_r == IDX_ZERO) ? depth : IDX_ZERO;
      dir_step_s = dir_r;
    end else begin
      idx_step_s = idx_tri_s;
      dir_step_s = dir_tri_s;
    end
`endif
  end

  // Next state: LFO only moves on valid samples; bypass forces it back to its reset state.
  always_comb begin
    y_nxt_s   = y_r;
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    dir_nxt_s = dir_r;
    if (x_valid) begin
      if (en) begin
        y_nxt_s = x >>> idx_r;
        if (step_s) begin
          cnt_nxt_s = RATE_ZERO;
          idx_nxt_s = idx_step_s;
          dir_nxt_s = dir_step_s;
        end else begin
          cnt_nxt_s = cnt_r + RATE_ONE;
        end
      end else begin
        y_nxt_s   = x;
        cnt_nxt_s = RATE_ZERO;
        idx_nxt_s = IDX_ZERO;
        dir_nxt_s = DIR_UP;
      end
    end else begin
      y_nxt_s = y_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_r       <= {DATA_WIDTH{1'b0}};
      y_valid_r <= 1'b0;
      cnt_r     <= RATE_ZERO;
      idx_r     <= IDX_ZERO;
      dir_r     <= DIR_UP;
    end else begin
      y_r       <= y_nxt_s;
      y_valid_r <= x_valid;
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      dir_r     <= dir_nxt_s;
    end
  end

  assign y         = y_r;
  assign y_valid   = y_valid_r;
  assign lfo_index = idx_r;

endmodule

// File: tb/tb_tremolo_lfo.sv
// Directed self-checking bench for tremolo_lfo; square-mode vectors build only with TREMOLO_SQUARE_EN.
module tb_tremolo_lfo;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               x_valid;
  logic signed [31:0] x;
  logic [15:0]        rate;
  logic [2:0]         depth;
`ifdef TREMOLO_SQUARE_EN
  logic               mode;
`endif
  logic signed [31:0] y;
  logic               y_valid;
  logic [2:0]         lfo_index;

  int n_vec = 0;
  int n_err = 0;

  tremolo_lfo dut (
    .clk(clk), .reset(reset), .en(en), .x_valid(x_valid), .x(x),
    .rate(rate), .depth(depth),
`ifdef TREMOLO_SQUARE_EN
    .mode(mode),
`endif
    .y(y), .y_valid(y_valid), .lfo_index(lfo_index)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [31:0] v, input logic vld);
    x = v;
    x_valid = vld;
    tick();
  endtask

  int tri_exp [16] = '{1024, 1024, 512, 512, 256, 256, 128, 128,
                       256, 256, 512, 512, 1024, 1024, 512, 512};
  int sgn_y   [5]  = '{-256, -128, -64, -32, -64};
  int sgn_idx [5]  = '{1, 2, 3, 2, 1};

  initial begin
    reset = 1'b1; en = 1'b1; x_valid = 1'b1; x = 32'sd100;
    rate = 16'd2; depth = 3'd3;
`ifdef TREMOLO_SQUARE_EN
    mode = 1'b0;
`endif

    // reset held two cycles with samples present
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_y", y, 0);
      check_val("rst_yv", y_valid, 0);
      check_val("rst_idx", lfo_index, 0);
    end
    reset = 1'b0;
    sample(32'sd100, 1'b1);
    check_val("post_rst_y", y, 100);
    check_val("post_rst_yv", y_valid, 1);

    // bypass ramp
    en = 1'b0;
    for (int v = -5; v <= 5; v++) begin
      sample(v, 1'b1);
      check_val("byp_y", y, v);
      check_val("byp_yv", y_valid, 1);
      check_val("byp_idx", lfo_index, 0);
    end

    // triangle, rate 2, depth 3
    en = 1'b1; rate = 16'd2; depth = 3'd3;
    for (int i = 0; i < 16; i++) begin
      sample(32'sd1024, 1'b1);
      check_val($sformatf("tri_y%0d", i), y, tri_exp[i]);
    end
    for (int i = 0; i < 2; i++) begin
      sample(32'sd7, 1'b0);
      check_val("idle_y", y, 512);
      check_val("idle_yv", y_valid, 0);
      check_val("idle_idx", lfo_index, 2);
    end

    // sign preservation with gaps
    en = 1'b0;
    sample(32'sd0, 1'b1);
    check_val("lfo_clr_idx", lfo_index, 0);
    en = 1'b1; rate = 16'd1; depth = 3'd3;
    for (int i = 0; i < 5; i++) begin
      sample(-32'sd256, 1'b1);
      check_val($sformatf("sgn_y%0d", i), y, sgn_y[i]);
      check_val($sformatf("sgn_idx%0d", i), lfo_index, sgn_idx[i]);
      sample(32'sd999, 1'b0);
      check_val("gap_y", y, sgn_y[i]);
      check_val("gap_yv", y_valid, 0);
      check_val("gap_idx", lfo_index, sgn_idx[i]);
    end

    // rate 0 behaves as rate 1
    en = 1'b0;
    sample(32'sd0, 1'b1);
    en = 1'b1; rate = 16'd0; depth = 3'd3;
    sample(32'sd8, 1'b1);
    check_val("rate0_idx1", lfo_index, 1);
    sample(32'sd8, 1'b1);
    check_val("rate0_idx2", lfo_index, 2);
    check_val("rate0_y", y, 4);

    // depth lowered below idx mid-sweep
    en = 1'b0;
    sample(32'sd0, 1'b1);
    en = 1'b1; rate = 16'd1; depth = 3'd7;
    for (int i = 0; i < 5; i++) sample(32'sd1024, 1'b1);
    check_val("dch_idx5", lfo_index, 5);
    depth = 3'd2;
    sample(32'sd1024, 1'b1);
    check_val("dch_y", y, 32);
    check_val("dch_idx", lfo_index, 2);
    depth = 3'd7;
    sample(32'sd1024, 1'b1);
    check_val("dch_dir_down", lfo_index, 1);
    check_val("dch_y2", y, 256);

    // reset mid-sweep drops the in-flight sample
    reset = 1'b1;
    sample(32'sd1024, 1'b1);
    check_val("mid_rst_y", y, 0);
    check_val("mid_rst_yv", y_valid, 0);
    check_val("mid_rst_idx", lfo_index, 0);
    reset = 1'b0; rate = 16'd3; depth = 3'd3;
    sample(32'sd1024, 1'b1);
    check_val("cnt_clr_a", lfo_index, 0);
    sample(32'sd1024, 1'b1);
    check_val("cnt_clr_b", lfo_index, 0);
    sample(32'sd1024, 1'b1);
    check_val("cnt_clr_c", lfo_index, 1);

`ifdef TREMOLO_SQUARE_EN
    // square chop
    en = 1'b0;
    sample(32'sd0, 1'b1);
    en = 1'b1; mode = 1'b1; rate = 16'd1; depth = 3'd4;
    for (int i = 0; i < 4; i++) begin
      sample(32'sd64, 1'b1);
      check_val($sformatf("sq_y%0d", i), y, (i % 2 == 0) ? 64 : 4);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
